alu_station: RTL and testbench

// - Reservation station plus single-cycle ALU for one arithmetic unit: accepts decoded ops with operands/tags from reg_stat,

---
 rtl/alu_station_pkg.sv | 37 +++
 rtl/alu_station_core.sv | 30 +++
 rtl/alu_station.sv | 182 ++++++++++++++++++
 tb/tb_alu_station.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_station_pkg.sv
// Shared types and constants for the ALU reservation station.
// Contents: word/register-address/tag types, tag encodings, ALU op
// encodings, and the per-operand record stored in each station entry.
package alu_station_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  regaddr_t;
   typedef logic [1:0]  regtag_t;

   localparam regtag_t UNLOCKED   = 2'd0;
   localparam regtag_t ALU_MASTER = 2'd1;
   localparam regtag_t ALU_SALVER = 2'd2;
   localparam regtag_t LOAD_STORE = 2'd3;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_SLL  = 4'd2,
      OP_SLT  = 4'd3,
      OP_SLTU = 4'd4,
      OP_XOR  = 4'd5,
      OP_SRL  = 4'd6,
      OP_SRA  = 4'd7,
      OP_OR   = 4'd8,
      OP_AND  = 4'd9
   } aluop_t;

   // ready=1 means value is valid; otherwise wait for producer tag on a
   // writeback bus carrying register addr.
   typedef struct packed {
      logic     ready;
      word_t    value;
      regtag_t  tag;
      regaddr_t addr;
   } operand_t;

endpackage

// File: rtl/alu_station_core.sv
// Purely combinational ALU: op, x, y -> result.
// Ports: op (operation), x/y (operands), result (32-bit result).
// Shift amount is y[4:0]; SLT/SLTU return 0 or 1.
module alu_core
   import alu_station_pkg::*;
(
   input  aluop_t op,
   input  word_t  x,
   input  word_t  y,
   output word_t  result
);

   always_comb begin
      result = '0;
      case (op)
         OP_ADD:  result = x + y;
         OP_SUB:  result = x - y;
         OP_SLL:  result = x << y[4:0];
         OP_SLT:  result = {31'b0, ($signed(x) < $signed(y))};
         OP_SLTU: result = {31'b0, (x < y)};
         OP_XOR:  result = x ^ y;
         OP_SRL:  result = x >> y[4:0];
         OP_SRA:  result = word_t'($signed(x) >>> y[4:0]);
         OP_OR:   result = x | y;
         OP_AND:  result = x & y;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu_station.sv
// Reservation station plus single-cycle ALU for one arithmetic unit.
// Accepts dispatched ops with operands/tags, snoops the three writeback
// buses until operands resolve, issues the oldest ready entry, and drives
// this unit's writeback bus (en_wo/addr_wo/data_wo).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rdy                       low = hold all state, en_wo forced low
//   en_disp, op, data*/tag*/addr*, addrd   dispatch interface
//   full                      all entries valid
//   en_w0/1/M, reg_write_addr0/1/M, write_data0/1/M   snooped buses
//   en_wo, addr_wo, data_wo   registered writeback output
module alu_station
   import alu_station_pkg::*;
#(
   parameter int      DEPTH  = 4,
   parameter regtag_t MY_TAG = ALU_MASTER
)(
   input  logic     clk,
   input  logic     rst,
   input  logic     rdy,
   input  logic     en_disp,
   input  aluop_t   op,
   input  word_t    datax,
   input  word_t    datay,
   input  regtag_t  tagx,
   input  regtag_t  tagy,
   input  regaddr_t addrx,
   input  regaddr_t addry,
   input  regaddr_t addrd,
   output logic     full,
   input  logic     en_w0,
   input  logic     en_w1,
   input  logic     en_wM,
   input  regaddr_t reg_write_addr0,
   input  regaddr_t reg_write_addr1,
   input  regaddr_t reg_write_addrM,
   input  word_t    write_data0,
   input  word_t    write_data1,
   input  word_t    write_dataM,
   output logic     en_wo,
   output regaddr_t addr_wo,
   output word_t    data_wo
);

   localparam int IW = $clog2(DEPTH);

   logic [DEPTH-1:0] valid_q;
   aluop_t           op_q    [DEPTH];
   regaddr_t         addrd_q [DEPTH];
   operand_t         opx_q   [DEPTH];
   operand_t         opy_q   [DEPTH];
   logic [IW-1:0]    age_q   [DEPTH];

   logic          iss_valid;
   logic [IW-1:0] iss_idx;
   logic [IW-1:0] iss_age;
   logic          alloc_ok;
   logic [IW-1:0] alloc_idx;
   logic [IW:0]   vcount;
   logic [IW:0]   new_age;
   logic          dispatch;
   operand_t      in_x;
   operand_t      in_y;
   word_t         alu_result;

   // Resolve a waiting operand against whichever bus its producer tag maps
   // to. The unit's own registered result is also matched directly, so
   // its dependants wake even without an external loopback of en_wo.
   function automatic operand_t wake(input operand_t o);
      operand_t r;
      r = o;
      if (!o.ready) begin
         if (o.tag == ALU_MASTER && en_w0 && reg_write_addr0 == o.addr) begin
            r.ready = 1'b1;
            r.value = write_data0;
         end else if (o.tag == ALU_SALVER && en_w1 && reg_write_addr1 == o.addr) begin
            r.ready = 1'b1;
            r.value = write_data1;
         end else if (o.tag == LOAD_STORE && en_wM && reg_write_addrM == o.addr) begin
            r.ready = 1'b1;
            r.value = write_dataM;
         end else if (o.tag == MY_TAG && en_wo && addr_wo == o.addr) begin
            r.ready = 1'b1;
            r.value = data_wo;
         end
      end
      return r;
   endfunction

   assign full = &valid_q;

   always_comb begin
      in_x = {(tagx == UNLOCKED), datax, tagx, addrx};
      in_y = {(tagy == UNLOCKED), datay, tagy, addry};
   end

   // Oldest ready entry has the smallest age rank.
   always_comb begin
      iss_valid = 1'b0;
      iss_idx   = '0;
      iss_age   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && opx_q[i].ready && opy_q[i].ready &&
             (!iss_valid || age_q[i] < iss_age)) begin
            iss_valid = 1'b1;
            iss_idx   = IW'(i);
            iss_age   = age_q[i];
         end
      end
   end

   always_comb begin
      alloc_ok  = 1'b0;
      alloc_idx = '0;
      vcount    = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            alloc_ok  = 1'b1;
            alloc_idx = IW'(i);
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         vcount = vcount + (IW+1)'(valid_q[i]);
      end
   end

   assign dispatch = en_disp && alloc_ok;
   // Ranks stay dense: the new entry ranks behind every survivor.
   assign new_age  = vcount - (IW+1)'(iss_valid);

   alu_core u_alu_core (
      .op     (op_q[iss_idx]),
      .x      (opx_q[iss_idx].value),
      .y      (opy_q[iss_idx].value),
      .result (alu_result)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         en_wo   <= 1'b0;
         addr_wo <= '0;
         data_wo <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            op_q[i]    <= OP_ADD;
            addrd_q[i] <= '0;
            opx_q[i]   <= '0;
            opy_q[i]   <= '0;
            age_q[i]   <= '0;
         end
      end else if (!rdy) begin
         en_wo <= 1'b0;
      end else begin
         en_wo <= iss_valid;
         if (iss_valid) begin
            addr_wo <= addrd_q[iss_idx];
            data_wo <= alu_result;
            valid_q[iss_idx] <= 1'b0;
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
               opx_q[i] <= wake(opx_q[i]);
               opy_q[i] <= wake(opy_q[i]);
               if (iss_valid && age_q[i] > iss_age) begin
                  age_q[i] <= age_q[i] - 1'b1;
               end
            end
         end
         // alloc_idx is always a free slot, so it never collides with the
         // per-entry updates above.
         if (dispatch) begin
            valid_q[alloc_idx] <= 1'b1;
            op_q[alloc_idx]    <= op;
            addrd_q[alloc_idx] <= addrd;
            opx_q[alloc_idx]   <= wake(in_x);
            opy_q[alloc_idx]   <= wake(in_y);
            age_q[alloc_idx]   <= new_age[IW-1:0];
         end
      end
   end

endmodule

// File: tb/tb_alu_station.sv
module tb_alu_station;
   import alu_station_pkg::*;

   localparam int DEPTH = 4;

   logic     clk = 1'b0;
   logic     rst, rdy, en_disp;
   aluop_t   op;
   word_t    datax, datay;
   regtag_t  tagx, tagy;
   regaddr_t addrx, addry, addrd;
   logic     full;
   logic     en_w0, en_w1, en_wM;
   regaddr_t reg_write_addr0, reg_write_addr1, reg_write_addrM;
   word_t    write_data0, write_data1, write_dataM;
   logic     en_wo;
   regaddr_t addr_wo;
   word_t    data_wo;

   // Unit is the master ALU: its own result bus is w0.
   assign en_w0           = en_wo;
   assign reg_write_addr0 = addr_wo;
   assign write_data0     = data_wo;

   alu_station #(.DEPTH(DEPTH), .MY_TAG(ALU_MASTER)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .en_disp(en_disp), .op(op),
      .datax(datax), .datay(datay), .tagx(tagx), .tagy(tagy),
      .addrx(addrx), .addry(addry), .addrd(addrd), .full(full),
      .en_w0(en_w0), .en_w1(en_w1), .en_wM(en_wM),
      .reg_write_addr0(reg_write_addr0), .reg_write_addr1(reg_write_addr1),
      .reg_write_addrM(reg_write_addrM),
      .write_data0(write_data0), .write_data1(write_data1), .write_dataM(write_dataM),
      .en_wo(en_wo), .addr_wo(addr_wo), .data_wo(data_wo)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      aluop_t   op;
      regaddr_t d;
      logic     rx, ry;
      word_t    vx, vy;
      regtag_t  tx, ty;
      regaddr_t ax, ay;
   } ment_t;

   ment_t    mq[$];          // in dispatch order: front is oldest
   logic     m_en   = 1'b0;
   regaddr_t m_addr = '0;
   word_t    m_data = '0;
   logic     m_full = 1'b0;
   logic     o_en;
   regaddr_t o_a;
   word_t    o_d;
   logic     mon_on = 1'b0;

   function automatic word_t ref_alu(input aluop_t o, input word_t x, input word_t y);
      int unsigned s;
      s = int'(y % 32);
      case (o)
         OP_ADD:  return x + y;
         OP_SUB:  return x + (~y) + 32'd1;
         OP_SLL:  return x << s;
         OP_SLT:  return ((x ^ 32'h8000_0000) < (y ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
         OP_SLTU: return (x < y) ? 32'd1 : 32'd0;
         OP_XOR:  return x ^ y;
         OP_SRL:  return x >> s;
         OP_SRA:  return (x >> s) | (x[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
         OP_OR:   return x | y;
         OP_AND:  return x & y;
         default: return 32'd0;
      endcase
   endfunction

   function automatic void mwake(inout logic r, inout word_t v, input regtag_t t, input regaddr_t a);
      if (r) return;
      if (t == ALU_MASTER && o_en && o_a == a) begin
         r = 1'b1; v = o_d;
      end else if (t == ALU_SALVER && en_w1 && reg_write_addr1 == a) begin
         r = 1'b1; v = write_data1;
      end else if (t == LOAD_STORE && en_wM && reg_write_addrM == a) begin
         r = 1'b1; v = write_dataM;
      end
   endfunction

   always @(posedge clk) begin : model
      int    n0;
      int    hit;
      ment_t e;
      o_en = m_en; o_a = m_addr; o_d = m_data;
      if (rst) begin
         mq.delete();
         m_en = 1'b0; m_addr = '0; m_data = '0;
      end else if (!rdy) begin
         m_en = 1'b0;
      end else begin
         n0  = mq.size();
         hit = -1;
         for (int i = 0; i < mq.size(); i++)
            if (hit < 0 && mq[i].rx && mq[i].ry) hit = i;
         if (hit >= 0) begin
            m_en   = 1'b1;
            m_addr = mq[hit].d;
            m_data = ref_alu(mq[hit].op, mq[hit].vx, mq[hit].vy);
            mq.delete(hit);
         end else begin
            m_en = 1'b0;
         end
         for (int i = 0; i < mq.size(); i++) begin
            e = mq[i];
            mwake(e.rx, e.vx, e.tx, e.ax);
            mwake(e.ry, e.vy, e.ty, e.ay);
            mq[i] = e;
         end
         if (en_disp && n0 < DEPTH) begin
            e.op = op; e.d = addrd;
            e.tx = tagx; e.ax = addrx; e.vx = datax; e.rx = (tagx == UNLOCKED);
            e.ty = tagy; e.ay = addry; e.vy = datay; e.ry = (tagy == UNLOCKED);
            mwake(e.rx, e.vx, e.tx, e.ax);
            mwake(e.ry, e.vy, e.ty, e.ay);
            mq.push_back(e);
         end
      end
      m_full = (mq.size() == DEPTH);
   end

   always @(negedge clk) begin
      if (mon_on) begin
         chk("mon_en_wo", {31'b0, en_wo}, {31'b0, m_en});
         chk("mon_full", {31'b0, full}, {31'b0, m_full});
         if (m_en) begin
            chk("mon_addr_wo", {27'b0, addr_wo}, {27'b0, m_addr});
            chk("mon_data_wo", data_wo, m_data);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      en_disp = 1'b0; en_w1 = 1'b0; en_wM = 1'b0;
   endtask

   task automatic disp(input aluop_t o, input word_t x, input word_t y,
                       input regtag_t tx, input regaddr_t ax,
                       input regtag_t ty, input regaddr_t ay, input regaddr_t d);
      en_disp = 1'b1; op = o; datax = x; datay = y;
      tagx = tx; addrx = ax; tagy = ty; addry = ay; addrd = d;
   endtask

   task automatic chk_out(input string name, input logic e, input regaddr_t a, input word_t d);
      chk({name, "_en"}, {31'b0, en_wo}, {31'b0, e});
      if (e) begin
         chk({name, "_addr"}, {27'b0, addr_wo}, {27'b0, a});
         chk({name, "_data"}, data_wo, d);
      end
   endtask

   typedef struct {
      aluop_t   op;
      word_t    x;
      word_t    y;
      regaddr_t d;
      word_t    exp;
   } vec_t;

   vec_t vt[13];

   initial begin
      vt[0]  = '{OP_ADD,  32'd5,          32'd7,          5'd3,  32'd12};
      vt[1]  = '{OP_SUB,  32'd0,          32'd1,          5'd4,  32'hFFFF_FFFF};
      vt[2]  = '{OP_SLL,  32'd1,          32'd31,         5'd5,  32'h8000_0000};
      vt[3]  = '{OP_SLL,  32'd3,          32'h21,         5'd6,  32'd6};
      vt[4]  = '{OP_SLT,  32'hFFFF_FFFF,  32'd1,          5'd7,  32'd1};
      vt[5]  = '{OP_SLTU, 32'hFFFF_FFFF,  32'd1,          5'd8,  32'd0};
      vt[6]  = '{OP_XOR,  32'hF0F0_F0F0,  32'hFF00_FF00,  5'd9,  32'h0FF0_0FF0};
      vt[7]  = '{OP_SRL,  32'h8000_0000,  32'd4,          5'd10, 32'h0800_0000};
      vt[8]  = '{OP_SRA,  32'h8000_0000,  32'd4,          5'd11, 32'hF800_0000};
      vt[9]  = '{OP_OR,   32'h0F,         32'hF0,         5'd12, 32'hFF};
      vt[10] = '{OP_AND,  32'hFF,         32'h3C,         5'd0,  32'h3C};
      vt[11] = '{OP_ADD,  32'hFFFF_FFFF,  32'd1,          5'd13, 32'd0};
      vt[12] = '{OP_SLT,  32'd1,          32'hFFFF_FFFF,  5'd14, 32'd0};

      rst = 1'b1; rdy = 1'b1; op = OP_ADD;
      datax = '0; datay = '0; tagx = UNLOCKED; tagy = UNLOCKED;
      addrx = '0; addry = '0; addrd = '0;
      reg_write_addr1 = '0; reg_write_addrM = '0; write_data1 = '0; write_dataM = '0;
      quiet();
      tick(); tick();
      chk_out("reset", 1'b0, '0, '0);
      chk("reset_addr", {27'b0, addr_wo}, 32'd0);
      chk("reset_data", data_wo, 32'd0);
      chk("reset_full", {31'b0, full}, 32'd0);
      rst = 1'b0;
      mon_on = 1'b1;

      // ready-operand vectors, 2-edge latency, one pulse each
      for (int i = 0; i < 13; i++) begin
         disp(vt[i].op, vt[i].x, vt[i].y, UNLOCKED, 5'd0, UNLOCKED, 5'd0, vt[i].d);
         tick();
         quiet();
         chk("vec_full", {31'b0, full}, 32'd0);
         chk_out("vec_early", 1'b0, '0, '0);
         tick();
         chk_out($sformatf("vec%0d", i), 1'b1, vt[i].d, vt[i].exp);
         tick();
         chk_out("vec_once", 1'b0, '0, '0);
      end

      // wakeup from wM; wrong addr on wM and wrong tag on w1 must not wake
      disp(OP_SUB, 32'd0, 32'd1, LOAD_STORE, 5'd4, UNLOCKED, 5'd0, 5'd8);
      tick(); quiet();
      tick();
      en_wM = 1'b1; reg_write_addrM = 5'd5; write_dataM = 32'd99;
      en_w1 = 1'b1; reg_write_addr1 = 5'd4; write_data1 = 32'd77;
      tick(); quiet();
      chk_out("wake_none", 1'b0, '0, '0);
      tick();
      chk_out("wake_none2", 1'b0, '0, '0);
      en_wM = 1'b1; reg_write_addrM = 5'd4; write_dataM = 32'd10;
      tick(); quiet();
      chk_out("wake_wait", 1'b0, '0, '0);
      tick();
      chk_out("wake_sub", 1'b1, 5'd8, 32'd9);
      tick();

      // dispatch-cycle bypass from w1
      disp(OP_SRA, 32'hFFFF_FFF8, 32'd0, UNLOCKED, 5'd0, ALU_SALVER, 5'd6, 5'd2);
      en_w1 = 1'b1; reg_write_addr1 = 5'd6; write_data1 = 32'd1;
      tick(); quiet();
      chk_out("byp_early", 1'b0, '0, '0);
      tick();
      chk_out("byp_sra", 1'b1, 5'd2, 32'hFFFF_FFFC);
      tick();

      // own-bus wakeup and own-bus dispatch bypass
      disp(OP_ADD, 32'd5, 32'd7, UNLOCKED, 5'd0, UNLOCKED, 5'd0, 5'd5);
      tick();
      disp(OP_SUB, 32'd0, 32'd2, ALU_MASTER, 5'd5, UNLOCKED, 5'd0, 5'd6);
      tick();
      chk_out("own_a", 1'b1, 5'd5, 32'd12);
      disp(OP_OR, 32'd0, 32'd1, ALU_MASTER, 5'd5, UNLOCKED, 5'd0, 5'd7);
      tick(); quiet();
      chk_out("own_gap", 1'b0, '0, '0);
      tick();
      chk_out("own_b", 1'b1, 5'd6, 32'd10);
      tick();
      chk_out("own_c", 1'b1, 5'd7, 32'd13);
      tick();
      chk_out("own_end", 1'b0, '0, '0);

      // age order + full with simultaneous dispatch/issue
      for (int i = 0; i < 4; i++) begin
         disp(OP_ADD, 32'd0, 32'(i), LOAD_STORE, 5'd9, UNLOCKED, 5'd0, 5'(10 + i));
         tick();
      end
      quiet();
      chk("age_full", {31'b0, full}, 32'd1);
      en_wM = 1'b1; reg_write_addrM = 5'd9; write_dataM = 32'd100;
      tick(); quiet();
      chk("age_full2", {31'b0, full}, 32'd1);
      disp(OP_ADD, 32'd50, 32'd50, UNLOCKED, 5'd0, UNLOCKED, 5'd0, 5'd30);
      tick();
      chk_out("age0", 1'b1, 5'd10, 32'd100);
      chk("age_notfull", {31'b0, full}, 32'd0);
      disp(OP_ADD, 32'd60, 32'd1, UNLOCKED, 5'd0, UNLOCKED, 5'd0, 5'd31);
      tick(); quiet();
      chk_out("age1", 1'b1, 5'd11, 32'd101);
      tick();
      chk_out("age2", 1'b1, 5'd12, 32'd102);
      tick();
      chk_out("age3", 1'b1, 5'd13, 32'd103);
      tick();
      chk_out("age_late_disp", 1'b1, 5'd31, 32'd61);
      tick();
      chk_out("age_drop", 1'b0, '0, '0);

      // rdy low holds the pending issue and suppresses the pulse
      disp(OP_XOR, 32'hA5, 32'h0F, UNLOCKED, 5'd0, UNLOCKED, 5'd0, 5'd15);
      tick(); quiet();
      rdy = 1'b0;
      tick();
      chk_out("rdy_hold", 1'b0, '0, '0);
      rdy = 1'b1;
      tick();
      chk_out("rdy_resume", 1'b1, 5'd15, 32'hAA);
      tick();

      // reset mid-flight
      for (int i = 0; i < 3; i++) begin
         disp(OP_ADD, 32'd0, 32'd1, LOAD_STORE, 5'd9, UNLOCKED, 5'd0, 5'd20);
         tick();
      end
      disp(OP_ADD, 32'd2, 32'd3, UNLOCKED, 5'd0, UNLOCKED, 5'd0, 5'd1);
      tick(); quiet();
      tick();
      chk_out("rst_pend", 1'b1, 5'd1, 32'd5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_en", {31'b0, en_wo}, 32'd0);
      chk("rst_addr", {27'b0, addr_wo}, 32'd0);
      chk("rst_data", data_wo, 32'd0);
      chk("rst_full", {31'b0, full}, 32'd0);
      en_wM = 1'b1; reg_write_addrM = 5'd9; write_dataM = 32'd7;
      tick(); quiet();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_silent", {31'b0, en_wo}, 32'd0);
      end

      // randomized traffic against the reference model
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 599) == 0);
         rdy = !(($urandom_range(0, 9) == 0) && !m_en);
         en_disp = ($urandom_range(0, 9) < 6);
         op = aluop_t'($urandom_range(0, 9));
         datax = $urandom(); datay = $urandom();
         tagx = ($urandom_range(0, 7) == 0) ? ALU_MASTER : regtag_t'($urandom_range(0, 3) & 2'b10 | {1'b0, 1'($urandom_range(0, 1))} & 2'b01);
         tagy = ($urandom_range(0, 1) == 0) ? UNLOCKED : (($urandom_range(0, 1) == 0) ? ALU_SALVER : LOAD_STORE);
         if (tagx == ALU_MASTER && $urandom_range(0, 1) == 0) tagx = UNLOCKED;
         addrx = 5'($urandom_range(0, 3)); addry = 5'($urandom_range(0, 3));
         addrd = 5'($urandom_range(0, 3));
         en_w1 = ($urandom_range(0, 9) < 3);
         reg_write_addr1 = 5'($urandom_range(0, 3)); write_data1 = $urandom();
         en_wM = ($urandom_range(0, 9) < 3);
         reg_write_addrM = 5'($urandom_range(0, 3)); write_dataM = $urandom();
         tick();
      end
      rst = 1'b0; rdy = 1'b1; quiet();
      for (int c = 0; c < 32; c++) begin
         en_w1 = 1'b1; reg_write_addr1 = 5'(c % 4); write_data1 = 32'(c);
         en_wM = 1'b1; reg_write_addrM = 5'(c % 4); write_dataM = 32'(c + 1000);
         tick();
      end
      quiet();
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
